// File: rtl/sub_seq64_if.sv
// Handshake and operand/result bundle for the multi-cycle subtractor.
// The master side supplies operands and accepts results. The slave side is the subtractor.
interface sub_seq64_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             zero;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, bout, zero
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, bout, zero
    );
endinterface

// File: rtl/sub_seq64.sv
// Multi-cycle unsigned subtractor: diff = a + ~b + 1.
// It processes CHUNK bits per clock, starting with the least-significant chunk.
// The carry (inverted borrow) passes between chunks through a register.
// After the last chunk, the result, borrow-out and zero flag are held until the consumer takes them.
module sub_seq64 #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic      clk,
    input  logic      rst,
    sub_seq64_if.slave bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int IW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb_n;
    logic [WIDTH-1:0] diff_r;
    logic [WIDTH-1:0] diff_nxt;
    logic             carry;
    logic             bout_r;
    logic             zero_r;
    logic [CW-1:0]    cnt;
    logic [IW-1:0]    base;
    logic [CHUNK:0]   sum;
    logic             last;

    // One chunk of a + ~b + cin. The result is CHUNK+1 bits wide, and the MSB is the carry into the next chunk.
    function automatic logic [CHUNK:0] chunk_add(input logic [CHUNK-1:0] x,
                                                 input logic [CHUNK-1:0] y,
                                                 input logic             cin);
        return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, cin};
    endfunction

    assign base = IW'(cnt) * IW'(CHUNK);
    assign last = (cnt == CW'(NCHUNK - 1));
    assign sum  = chunk_add(opa[base +: CHUNK], opb_n[base +: CHUNK], carry);

    // Merge the current chunk into the running result so the zero flag can see the final value.
    always_comb begin
        diff_nxt                  = diff_r;
        diff_nxt[base +: CHUNK]   = sum[CHUNK-1:0];
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: accept in IDLE, walk the chunks in RUN, hold in DONE until the consumer takes the result
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_nxt = RUN;
            RUN:     if (last)          state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    // Datapath: latch the operands, then add one chunk per RUN cycle and register the flags on the last chunk.
    // The operand registers do not need a reset. They are always loaded before use.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            carry  <= 1'b1;
            diff_r <= '0;
            bout_r <= 1'b0;
            zero_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        opa   <= bus.a;
                        opb_n <= ~bus.b;
                        carry <= 1'b1;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    diff_r <= diff_nxt;
                    carry  <= sum[CHUNK];
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        bout_r <= ~sum[CHUNK];
                        zero_r <= (diff_nxt == '0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.diff      = diff_r;
    assign bus.bout      = bout_r;
    assign bus.zero      = zero_r;

endmodule

// File: tb/tb_sub_seq64.sv
// Bench for sub_seq64. It uses three instances with CHUNK = 16, 4 and 64, and compares each against plain 64-bit arithmetic.
module tb_sub_seq64;
    logic clk;
    logic rst;

    int checks   = 0;
    int failures = 0;

    // Index 0: CHUNK=16, index 1: CHUNK=4, index 2: CHUNK=64
    int          nc [3] = '{4, 16, 1};
    logic        iv   [3];
    logic        ordy [3];
    logic [63:0] a_s  [3];
    logic [63:0] b_s  [3];
    logic        irdy [3];
    logic        ov   [3];
    logic [63:0] df   [3];
    logic        bo   [3];
    logic        zr   [3];

    sub_seq64_if #(.WIDTH(64)) if16 ();
    sub_seq64_if #(.WIDTH(64)) if4  ();
    sub_seq64_if #(.WIDTH(64)) if64 ();

    sub_seq64 #(.WIDTH(64), .CHUNK(16)) u16 (.clk(clk), .rst(rst), .bus(if16.slave));
    sub_seq64 #(.WIDTH(64), .CHUNK(4))  u4  (.clk(clk), .rst(rst), .bus(if4.slave));
    sub_seq64 #(.WIDTH(64), .CHUNK(64)) u64 (.clk(clk), .rst(rst), .bus(if64.slave));

    assign if16.in_valid  = iv[0];
    assign if16.a         = a_s[0];
    assign if16.b         = b_s[0];
    assign if16.out_ready = ordy[0];
    assign irdy[0] = if16.in_ready;
    assign ov[0]   = if16.out_valid;
    assign df[0]   = if16.diff;
    assign bo[0]   = if16.bout;
    assign zr[0]   = if16.zero;

    assign if4.in_valid  = iv[1];
    assign if4.a         = a_s[1];
    assign if4.b         = b_s[1];
    assign if4.out_ready = ordy[1];
    assign irdy[1] = if4.in_ready;
    assign ov[1]   = if4.out_valid;
    assign df[1]   = if4.diff;
    assign bo[1]   = if4.bout;
    assign zr[1]   = if4.zero;

    assign if64.in_valid  = iv[2];
    assign if64.a         = a_s[2];
    assign if64.b         = b_s[2];
    assign if64.out_ready = ordy[2];
    assign irdy[2] = if64.in_ready;
    assign ov[2]   = if64.out_valid;
    assign df[2]   = if64.diff;
    assign bo[2]   = if64.bout;
    assign zr[2]   = if64.zero;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    // Full transaction on instance k. The expected results come from ordinary 64-bit arithmetic.
    // During a DONE hold, the bench applies random operand and valid noise.
    task automatic run_op(input int k, input logic [63:0] a, input logic [63:0] b, input int hold);
        logic [63:0] ed;
        logic        eb;
        logic        ez;
        int          cyc;
        ed = a - b;
        eb = (a < b);
        ez = (a == b);
        @(negedge clk);
        a_s[k]  = a;
        b_s[k]  = b;
        iv[k]   = 1'b1;
        ordy[k] = 1'b0;
        chk("in_ready_idle", k, 64'(irdy[k]), 64'd1);
        @(negedge clk);
        iv[k]  = 1'b0;
        a_s[k] = {$urandom, $urandom};
        b_s[k] = {$urandom, $urandom};
        cyc = 0;
        while (!ov[k] && cyc < 40) begin
            chk("in_ready_run", k, 64'(irdy[k]), 64'd0);
            @(negedge clk);
            cyc++;
        end
        chk("run_len", k, 64'(cyc), 64'(nc[k]));
        chk("diff", k, df[k], ed);
        chk("bout", k, 64'(bo[k]), 64'(eb));
        chk("zero", k, 64'(zr[k]), 64'(ez));
        chk("in_ready_done", k, 64'(irdy[k]), 64'd0);
        for (int h = 0; h < hold; h++) begin
            iv[k]  = 1'($urandom);
            a_s[k] = {$urandom, $urandom};
            b_s[k] = {$urandom, $urandom};
            @(negedge clk);
            chk("hold_valid", k, 64'(ov[k]), 64'd1);
            chk("hold_ready", k, 64'(irdy[k]), 64'd0);
            chk("hold_diff", k, df[k], ed);
            chk("hold_bout", k, 64'(bo[k]), 64'(eb));
            chk("hold_zero", k, 64'(zr[k]), 64'(ez));
        end
        iv[k]   = 1'b0;
        ordy[k] = 1'b1;
        @(negedge clk);
        ordy[k] = 1'b0;
        chk("out_valid_cleared", k, 64'(ov[k]), 64'd0);
        chk("in_ready_back", k, 64'(irdy[k]), 64'd1);
        chk("diff_kept", k, df[k], ed);
    endtask

    initial begin
        logic [63:0] ra;
        logic [63:0] rb;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            iv[k]   = 1'b0;
            ordy[k] = 1'b0;
            a_s[k]  = '0;
            b_s[k]  = '0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("rst_in_ready", k, 64'(irdy[k]), 64'd1);
            chk("rst_out_valid", k, 64'(ov[k]), 64'd0);
            chk("rst_diff", k, df[k], 64'd0);
            chk("rst_bout", k, 64'(bo[k]), 64'd0);
            chk("rst_zero", k, 64'(zr[k]), 64'd0);
        end
        rst = 1'b0;

        // Directed cases on every chunk size
        for (int k = 0; k < 3; k++) begin
            run_op(k, 64'd5, 64'd1, 0);
            run_op(k, 64'd0, 64'd1, 0);
            run_op(k, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 0);
            run_op(k, 64'h0000_0001_0000_0000, 64'd1, 0);
            run_op(k, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0);
            run_op(k, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        end

        // Back-pressure for 10 cycles with input noise, followed immediately by the next operation
        run_op(0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 10);
        run_op(0, 64'd100, 64'd58, 0);
        run_op(1, 64'd3, 64'd9, 4);

        // Reset during the second RUN cycle
        @(negedge clk);
        a_s[0] = 64'hDEAD_BEEF_0000_0000;
        b_s[0] = 64'd1;
        iv[0]  = 1'b1;
        @(negedge clk);
        iv[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_in_ready", 0, 64'(irdy[0]), 64'd1);
        chk("midrst_out_valid", 0, 64'(ov[0]), 64'd0);
        chk("midrst_diff", 0, df[0], 64'd0);
        chk("midrst_bout", 0, 64'(bo[0]), 64'd0);
        chk("midrst_zero", 0, 64'(zr[0]), 64'd0);
        run_op(0, 64'd7, 64'd3, 0);

        // Randomized operands, with equal and a<b cases forced in part of the runs
        for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < 8; n++) begin
                ra = {$urandom, $urandom};
                rb = {$urandom, $urandom};
                if (n % 4 == 1) rb = ra;
                if (n % 4 == 2) rb = ra + 64'(1 + $urandom_range(0, 1000));
                if (n % 4 == 3) rb = {ra[63:32], $urandom};
                run_op(k, ra, rb, $urandom_range(0, 3));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
